acc_cpu_ctrl: RTL and testbench
===============================

Name: acc_cpu_ctrl

Overview:
- Fetch/decode/execute sequencer for the 8-bit accumulator CPU. Sits directly upstream of the ALU.
- Drives the ALU 4-bit op code and operand (iIN2 side), the accumulator write enable, and a req/ack memory interface shared by instruction and data.
- Accumulator data, zero flag and the ALU result path are external; only control and operand capture live here.

Parameters:
DW  8  data/instruction width; instruction = {opcode[DW-1:DW-4], addr[DW-5:0]}; AW = DW-4 (4 at default)

Ports:
iCLK  in  1  clock, all state changes on rising edge
iRST_N  in  1  synchronous active-low reset
iRUN  in  1  start execution from IDLE
iACC_Z  in  1  accumulator == 0, sampled in EXEC
iMEM_RDATA  in  DW  memory read data, valid when iMEM_ACK=1
iMEM_ACK  in  1  memory completes current rd/wr this cycle
oMEM_ADDR  out  AW  memory address
oMEM_RD  out  1  read request
oMEM_WR  out  1  write request; wdata is ALU oZ, wired outside
oALU_OP  out  4  op code to ALU
oOPND  out  DW  data operand to ALU iIN2
oACC_WE  out  1  accumulator load strobe (one cycle)
oPC  out  AW  program counter
oHALT  out  1  processor halted

Behaviour:
- Reset (iRST_N=0 at edge): state=IDLE, PC=0, IR=0, oOPND=0.
  - All outputs 0 except oALU_OP=4'b0101 (pass-through default).
  - Reset mid-handshake abandons the transfer; oMEM_RD/oMEM_WR drop on the next cycle.
- States: IDLE, FETCH, DECODE, MEM, EXEC, HALT.
- IDLE: outputs idle. iRUN=1 -> FETCH.
- FETCH:
  - oMEM_RD=1, oMEM_ADDR=PC, held stable until iMEM_ACK=1.
  - On ack: IR<=iMEM_RDATA -> DECODE.
- DECODE (1 cycle): PC<=PC+1, wrapping 2^AW-1 -> 0. Next state:
  - opcode 0100 or 0110 -> MEM (read)
  - opcode 0101 -> MEM (write)
  - 1111 -> HALT
  - else -> EXEC
- MEM read (ADD/LDA):
  - oMEM_RD=1, oMEM_ADDR=IR addr.
  - On ack: oOPND<=iMEM_RDATA -> EXEC.
- MEM write (STA):
  - oMEM_WR=1, oMEM_ADDR=IR addr, oALU_OP=0101, held until ack.
  - On ack -> FETCH. oACC_WE never asserted for STA.
- EXEC (1 cycle): oALU_OP=IR opcode.
  - oACC_WE=1 for 0000 CLA, 0001 COM, 0010 SHR, 0011 CSL, 0100 ADD, 0110 LDA.
  - 0111 JMP: PC<=addr, no acc write.
  - 1000 BRZ: PC<=addr if iACC_Z=1, else PC unchanged.
  - 1001–1110: NOP, no writes.
  - Next state: FETCH.
- HALT: oHALT=1, all requests 0. Stays until reset (iRUN ignored).
- Outside EXEC and MEM-write, oALU_OP=0101. oOPND holds its last captured value.
- oMEM_RD and oMEM_WR are never both 1. A request is asserted from state entry and deasserted the cycle after ack is sampled.
- iMEM_ACK while no request is pending is ignored.
- Latency with zero-wait memory (ack in first request cycle):
  - register op or JMP/BRZ: 3 cycles
  - ADD/LDA: 4 cycles
  - STA: 3 cycles
  - Each memory wait cycle adds 1.
- oPC shows the PC register: after DECODE it already points to the next instruction. BRZ/JMP take effect for the next FETCH.
- No write hazard: the acc update at the EXEC edge is visible before the following EXEC.

Test Plan:
- Reset + run, zero-wait mem, mem[0]=8'h00 (CLA):
  - FETCH addr 0 at cycle 1, DECODE, then EXEC with oALU_OP=0000 and oACC_WE=1 for exactly one cycle at cycle 3.
  - oPC=1, next FETCH addr 1.
- mem[1]=8'h6A (LDA 0xA), mem[10]=8'h37, ack delayed 2 cycles each request:
  - oOPND=8'h37 on entering EXEC, oALU_OP=0110 with oACC_WE=1.
  - Total 8 cycles FETCH-to-FETCH.
- STA 0x5 (8'h55):
  - oMEM_WR=1, oMEM_ADDR=5, oALU_OP=0101 until ack.
  - oACC_WE stays 0, oMEM_RD stays 0.
- Branch: BRZ 0x3 (8'h83) with iACC_Z=1 -> next fetch addr 3; same with iACC_Z=0 -> next fetch addr PC+1.
  - Program ending at addr 15 with a NOP -> fetch wraps to addr 0.
- mem[k]=8'hF0 -> oHALT=1 after DECODE and no further requests for 20 cycles despite iRUN=1.
  - Reset then run restarts FETCH at 0.
- Assert iRST_N=0 while oMEM_RD is waiting for ack:
  - next cycle IDLE, oMEM_RD=0, PC=0.
  - A late iMEM_ACK has no effect.

Source files
------------

// File: rtl/acc_cpu_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Drives ALU op/operand, accumulator write strobe and a shared req/ack memory port.
module acc_cpu_ctrl #(
    parameter int DW = 8
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iRUN,
    input  logic          iACC_Z,
    input  logic [DW-1:0] iMEM_RDATA,
    input  logic          iMEM_ACK,
    output logic [DW-5:0] oMEM_ADDR,
    output logic          oMEM_RD,
    output logic          oMEM_WR,
    output logic [3:0]    oALU_OP,
    output logic [DW-1:0] oOPND,
    output logic          oACC_WE,
    output logic [DW-5:0] oPC,
    output logic          oHALT
);
    localparam int AW = DW - 4;

    localparam logic [3:0] OP_CLA = 4'b0000;
    localparam logic [3:0] OP_COM = 4'b0001;
    localparam logic [3:0] OP_SHR = 4'b0010;
    localparam logic [3:0] OP_CSL = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_STA = 4'b0101;
    localparam logic [3:0] OP_LDA = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;
    localparam logic [3:0] OP_BRZ = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [3:0] OP_PASS = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] ir;
    logic [AW-1:0] pc, pc_nxt;
    logic          ir_load, opnd_load;
    logic [3:0]    opcode;
    logic [AW-1:0] ir_addr;
    logic          is_store;

    assign opcode   = ir[DW-1:DW-4];
    assign ir_addr  = ir[AW-1:0];
    assign is_store = (opcode == OP_STA);
    assign oPC      = pc;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            oOPND <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (ir_load)   ir    <= iMEM_RDATA;
            if (opnd_load) oOPND <= iMEM_RDATA;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_load   = 1'b0;
        opnd_load = 1'b0;
        oMEM_ADDR = '0;
        oMEM_RD   = 1'b0;
        oMEM_WR   = 1'b0;
        oALU_OP   = OP_PASS;
        oACC_WE   = 1'b0;
        oHALT     = 1'b0;
        case (state)
            S_IDLE: begin
                if (iRUN) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                oMEM_RD   = 1'b1;
                oMEM_ADDR = pc;
                if (iMEM_ACK) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                pc_nxt = pc + AW'(1);
                case (opcode)
                    OP_ADD, OP_LDA, OP_STA: state_nxt = S_MEM;
                    OP_HLT:                 state_nxt = S_HALT;
                    default:                state_nxt = S_EXEC;
                endcase
            end
            S_MEM: begin
                oMEM_ADDR = ir_addr;
                // Stores hold the ALU in pass-through so oZ presents the accumulator as write data.
                if (is_store) oMEM_WR = 1'b1;
                else          oMEM_RD = 1'b1;
                if (iMEM_ACK) begin
                    if (is_store) begin
                        state_nxt = S_FETCH;
                    end else begin
                        opnd_load = 1'b1;
                        state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                oALU_OP   = opcode;
                state_nxt = S_FETCH;
                case (opcode)
                    OP_CLA, OP_COM, OP_SHR, OP_CSL, OP_ADD, OP_LDA: oACC_WE = 1'b1;
                    OP_JMP: pc_nxt = ir_addr;
                    OP_BRZ: if (iACC_Z) pc_nxt = ir_addr;
                    default: ;
                endcase
            end
            S_HALT: begin
                oHALT = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Bench for acc_cpu_ctrl: an instruction-level model expands each program into an expected
// per-cycle output trace, and the DUT is compared against it every cycle.
module tb_acc_cpu_ctrl;
    logic       iCLK = 1'b0;
    logic       iRST_N, iRUN, iACC_Z, iMEM_ACK;
    logic [7:0] iMEM_RDATA;
    logic [3:0] oMEM_ADDR, oALU_OP, oPC;
    logic       oMEM_RD, oMEM_WR, oACC_WE, oHALT;
    logic [7:0] oOPND;

    acc_cpu_ctrl #(.DW(8)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iRUN(iRUN), .iACC_Z(iACC_Z),
        .iMEM_RDATA(iMEM_RDATA), .iMEM_ACK(iMEM_ACK), .oMEM_ADDR(oMEM_ADDR),
        .oMEM_RD(oMEM_RD), .oMEM_WR(oMEM_WR), .oALU_OP(oALU_OP), .oOPND(oOPND),
        .oACC_WE(oACC_WE), .oPC(oPC), .oHALT(oHALT)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic       rd, wr;
        logic [3:0] addr, alu;
        logic       we, halt;
        logic [7:0] opnd;
        logic [3:0] pc;
        logic       ack, z;
        logic [7:0] rdata;
    } cyc_t;

    logic [7:0] mem [16];
    cyc_t       tr[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic rd, input logic wr, input logic [3:0] addr, input logic [3:0] alu,
                        input logic we, input logic halt, input logic [7:0] opnd, input logic [3:0] pc,
                        input logic ack, input logic z, input logic [7:0] rdata);
        cyc_t c;
        c.rd = rd; c.wr = wr; c.addr = addr; c.alu = alu; c.we = we; c.halt = halt;
        c.opnd = opnd; c.pc = pc; c.ack = ack; c.z = z; c.rdata = rdata;
        tr.push_back(c);
    endtask

    // One memory transfer: w wait cycles, then the ack cycle.
    task automatic mem_req(input logic rd, input logic wr, input logic [3:0] a, input logic [7:0] o,
                           input logic [3:0] p, input int w);
        for (int i = 0; i <= w; i++)
            push(rd, wr, a, 4'h5, 1'b0, 1'b0, o, p, (i == w), 1'($urandom),
                 (i == w) ? mem[a] : 8'($urandom));
    endtask

    task automatic build(input int n, input int lo, input int hi, input int zmode);
        logic [3:0] p, op, a;
        logic [7:0] o;
        logic       halted, z;
        tr.delete();
        p = 4'h0; o = 8'h00; halted = 1'b0;
        push(1'b0, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0, o, p, 1'($urandom), 1'($urandom), 8'($urandom));
        while (tr.size() < n) begin
            if (halted) begin
                push(1'b0, 1'b0, 4'h0, 4'h5, 1'b0, 1'b1, o, p, 1'($urandom), 1'($urandom), 8'($urandom));
            end else begin
                op = mem[p][7:4];
                a  = mem[p][3:0];
                mem_req(1'b1, 1'b0, p, o, p, $urandom_range(hi, lo));
                push(1'b0, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0, o, p, 1'($urandom), 1'($urandom), 8'($urandom));
                p = p + 4'h1;
                if (op == 4'h4 || op == 4'h6) begin
                    mem_req(1'b1, 1'b0, a, o, p, $urandom_range(hi, lo));
                    o = mem[a];
                    push(1'b0, 1'b0, 4'h0, op, 1'b1, 1'b0, o, p, 1'($urandom), 1'($urandom), 8'($urandom));
                end else if (op == 4'h5) begin
                    mem_req(1'b0, 1'b1, a, o, p, $urandom_range(hi, lo));
                end else if (op == 4'hF) begin
                    halted = 1'b1;
                end else begin
                    z = (zmode == 2) ? 1'($urandom) : (zmode == 1);
                    push(1'b0, 1'b0, 4'h0, op, (op <= 4'h3), 1'b0, o, p, 1'($urandom), z, 8'($urandom));
                    if (op == 4'h7 || (op == 4'h8 && z)) p = a;
                end
            end
        end
    endtask

    task automatic do_reset();
        iRST_N = 1'b0; iRUN = 1'b0; iMEM_ACK = 1'b0; iACC_Z = 1'b0; iMEM_RDATA = 8'h00;
        repeat (2) @(posedge iCLK);
        #1 iRST_N = 1'b1;
    endtask

    task automatic run_trace(input string tag);
        logic [23:0] act, exp;
        logic        req;
        do_reset();
        for (int k = 0; k < tr.size(); k++) begin
            iRUN = 1'b1; iMEM_ACK = tr[k].ack; iACC_Z = tr[k].z; iMEM_RDATA = tr[k].rdata;
            @(negedge iCLK);
            req = tr[k].rd | tr[k].wr;
            exp = {tr[k].rd, tr[k].wr, req ? tr[k].addr : 4'h0, tr[k].alu, tr[k].we, tr[k].halt,
                   tr[k].opnd, tr[k].pc};
            act = {oMEM_RD, oMEM_WR, req ? oMEM_ADDR : 4'h0, oALU_OP, oACC_WE, oHALT, oOPND, oPC};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got rd=%b wr=%b addr=%h op=%h we=%b halt=%b opnd=%h pc=%h want rd=%b wr=%b addr=%h op=%h we=%b halt=%b opnd=%h pc=%h",
                         tag, k, act[23], act[22], act[21:18], act[17:14], act[13], act[12], act[11:4], act[3:0],
                         exp[23], exp[22], exp[21:18], exp[17:14], exp[13], exp[12], exp[11:4], exp[3:0]);
            end
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    initial begin
        // CLA then LDA 0xA with two wait cycles per request
        fill(8'h90); mem[0] = 8'h00; mem[1] = 8'h6A; mem[10] = 8'h37;
        build(40, 2, 2, 0);
        chk("cla_exec_op", {tr[5].alu, 3'b0, tr[5].we}, {4'h0, 3'b0, 1'b1});
        chk("lda_mem_addr", {tr[12].rd, tr[12].addr}, {1'b1, 4'hA});
        chk("lda_exec", {tr[13].opnd, tr[13].alu, 3'b0, tr[13].we}, {8'h37, 4'h6, 3'b0, 1'b1});
        chk("lda_next_fetch", {tr[14].rd, tr[14].addr, tr[14].pc}, {1'b1, 4'h2, 4'h2});
        run_trace("lda");

        // zero-wait CLA
        fill(8'h90); mem[0] = 8'h00;
        build(20, 0, 0, 0);
        chk("cla_fetch", {tr[1].rd, tr[1].addr}, {1'b1, 4'h0});
        chk("cla_we_once", {tr[2].we, tr[3].we, tr[4].we}, 3'b010);
        chk("cla_next", {tr[4].rd, tr[4].addr, tr[4].pc}, {1'b1, 4'h1, 4'h1});
        run_trace("cla");

        // STA 0x5 with one wait cycle
        fill(8'h90); mem[0] = 8'h55;
        build(20, 1, 1, 0);
        chk("sta_req", {tr[4].wr, tr[4].rd, tr[4].addr, tr[4].alu, tr[4].we}, {1'b1, 1'b0, 4'h5, 4'h5, 1'b0});
        chk("sta_next", {tr[6].rd, tr[6].addr}, {1'b1, 4'h1});
        run_trace("sta");

        // BRZ taken and not taken
        fill(8'h90); mem[0] = 8'h83;
        build(20, 0, 0, 1);
        chk("brz_taken", {tr[4].rd, tr[4].addr}, {1'b1, 4'h3});
        run_trace("brz1");
        build(20, 0, 0, 0);
        chk("brz_not_taken", {tr[4].rd, tr[4].addr}, {1'b1, 4'h1});
        run_trace("brz0");

        // straight-line NOPs wrap from 15 to 0
        fill(8'h90);
        build(60, 0, 0, 2);
        chk("wrap_15", {tr[46].rd, tr[46].addr}, {1'b1, 4'hF});
        chk("wrap_0", {tr[49].rd, tr[49].addr, tr[49].pc}, {1'b1, 4'h0, 4'h0});
        run_trace("wrap");

        // HALT at addr 2 stays quiet despite iRUN
        fill(8'h90); mem[2] = 8'hF0;
        build(40, 0, 0, 2);
        chk("halt_entry", {tr[9].halt, tr[8].halt}, 2'b10);
        chk("halt_quiet", {tr[30].halt, tr[30].rd, tr[30].wr}, 3'b100);
        run_trace("halt");

        // random programs with random wait states and zero flag
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] = 8'($urandom);
                if (mem[i][7:4] == 4'hF && $urandom_range(3, 0) != 0) mem[i][7:4] = 4'h9;
            end
            build(90, 0, 3, 2);
            run_trace($sformatf("rand%0d", r));
        end

        // reset while a fetch is waiting for ack; late ack must be ignored
        do_reset();
        iRUN = 1'b1; iMEM_ACK = 1'b0;
        @(posedge iCLK); #1;
        @(negedge iCLK);
        chk("mid_fetch_rd", {oMEM_RD, oMEM_ADDR}, {1'b1, 4'h0});
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iRST_N = 1'b0;
        @(posedge iCLK); #1;
        iRST_N = 1'b1; iRUN = 1'b0;
        @(negedge iCLK);
        chk("rst_mid_rd", {oMEM_RD, oMEM_WR, oHALT, oPC}, {3'b000, 4'h0});
        iMEM_ACK = 1'b1; iMEM_RDATA = 8'hF0;
        @(posedge iCLK); #1;
        iMEM_ACK = 1'b0;
        @(negedge iCLK);
        chk("late_ack", {oMEM_RD, oHALT, oPC, oOPND, oALU_OP}, {2'b00, 4'h0, 8'h00, 4'h5});
        iRUN = 1'b1;
        @(posedge iCLK); #1;
        @(negedge iCLK);
        chk("restart_fetch", {oMEM_RD, oMEM_ADDR, oHALT}, {1'b1, 4'h0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
